// File: rtl/interrupt_controller_if.sv
// Bus bundle between the interrupt controller and its surroundings.
//
// Purpose: carries the interrupt source lines, the configuration register
// port and the cpu irq/irq_ack/eoi handshake as one connection.
//
// Signals:
//   irq_in     : interrupt source lines (sources -> controller)
//   cfg_we     : configuration write strobe
//   cfg_addr   : configuration register select
//   cfg_wdata  : configuration write data
//   cfg_rdata  : configuration read data (controller -> host)
//   irq        : interrupt request to the cpu
//   irq_vector : handler address, valid while irq=1
//   irq_ack    : one-cycle pulse from the cpu when it takes the interrupt
//   eoi        : one-cycle pulse from the cpu on handler return
//
// Modports: master = cpu/host/source side, slave = controller side.
interface interrupt_controller_if #(
  parameter int N_IRQ     = 8,
  parameter int VEC_WIDTH = 10
);
  logic [N_IRQ-1:0]     irq_in;
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [N_IRQ-1:0]     cfg_wdata;
  logic [N_IRQ-1:0]     cfg_rdata;
  logic                 irq;
  logic [VEC_WIDTH-1:0] irq_vector;
  logic                 irq_ack;
  logic                 eoi;

  modport master (
    output irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
    input  cfg_rdata, irq, irq_vector
  );

  modport slave (
    input  irq_in, cfg_we, cfg_addr, cfg_wdata, irq_ack, eoi,
    output cfg_rdata, irq, irq_vector
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, nesting interrupt controller.
//
// Purpose: captures rising edges on irq_in into a pending register, masks
// them, and presents the highest-priority eligible line (index 0 highest)
// to the cpu with a stable vector. Lines taken by the cpu move into the
// in-service register (isr) until the cpu signals end-of-interrupt.
// Only a strictly higher priority line may preempt an in-service one.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : interrupt_controller_if.slave (irq_in, cfg_*, irq, irq_vector,
//           irq_ack, eoi)
//
// Configuration registers (cfg_addr):
//   0 mask    : read/write, 1 = line masked
//   1 pending : read; writing 1 clears that bit
//   2 isr     : read-only
//   3 status  : bit 0 irq, bit 1 err, bits [4:2] sel; write bit 7 = 1 clears err
// The status layout assumes N_IRQ = 8.
module interrupt_controller #(
  parameter int                   N_IRQ      = 8,
  parameter int                   VEC_WIDTH  = 10,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 10'h3F0,
  parameter int                   VEC_STRIDE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_controller_if.slave bus
);

  localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t               state, state_n;
  logic [N_IRQ-1:0]     irq_prev;
  logic [N_IRQ-1:0]     pending, pending_n;
  logic [N_IRQ-1:0]     mask;
  logic [N_IRQ-1:0]     isr, isr_n;
  logic                 err, err_n;
  logic [SEL_W-1:0]     sel_r;
  logic [VEC_WIDTH-1:0] vec_r;

  logic [N_IRQ-1:0]     rise, cand, pending_clr, sel_oh;
  logic [SEL_W-1:0]     sel, isr_low;
  logic                 eligible, ack_take, load_sel;
  logic                 wr_mask, wr_pend, wr_status;
  logic [N_IRQ-1:0]     status;

  // Index of the lowest set bit (highest priority); 0 when v is empty.
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
    lowest_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

  function automatic logic [VEC_WIDTH-1:0] vec_of(input logic [SEL_W-1:0] s);
    vec_of = VEC_BASE + VEC_WIDTH'(s) * VEC_WIDTH'(VEC_STRIDE);
  endfunction

  assign rise      = bus.irq_in & ~irq_prev;
  assign cand      = pending & ~mask;
  assign sel       = lowest_idx(cand);
  assign isr_low   = lowest_idx(isr);
  assign eligible  = (|cand) && ((isr == '0) || (sel < isr_low));
  assign ack_take  = (state == REQ) && bus.irq_ack;
  assign sel_oh    = N_IRQ'(1) << sel_r;

  assign wr_mask   = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_pend   = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign wr_status = bus.cfg_we && (bus.cfg_addr == 2'd3);

  // A fresh edge wins over a clear in the same cycle so no event is lost.
  assign pending_clr = (ack_take ? sel_oh : '0) | (wr_pend ? bus.cfg_wdata : '0);
  assign pending_n   = (pending & ~pending_clr) | rise;

  // eoi retires the lowest set isr bit first, then the ack adds sel_r.
  always_comb begin
    isr_n = isr;
    if (bus.eoi && (isr != '0)) isr_n = isr & (isr - N_IRQ'(1));
    if (ack_take) isr_n = isr_n | sel_oh;
  end

  assign err_n = (err & ~(wr_status && bus.cfg_wdata[7])) |
                 (bus.eoi && (isr == '0));

  always_comb begin
    state_n  = state;
    load_sel = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) begin
          state_n  = REQ;
          load_sel = 1'b1;
        end
      end
      REQ: begin
        // The request is frozen; it only ends on ack or when its own line
        // stops being a valid candidate (masked or cleared via cfg).
        if (ack_take) state_n = IDLE;
        else if (!(pending[sel_r] && !mask[sel_r])) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      irq_prev <= '1;
      pending  <= '0;
      mask     <= '1;
      isr      <= '0;
      err      <= 1'b0;
      sel_r    <= '0;
      vec_r    <= VEC_BASE;
    end else begin
      state    <= state_n;
      irq_prev <= bus.irq_in;
      pending  <= pending_n;
      isr      <= isr_n;
      err      <= err_n;
      if (wr_mask) mask <= bus.cfg_wdata;
      if (load_sel) begin
        sel_r <= sel;
        vec_r <= vec_of(sel);
      end
    end
  end

  always_comb begin
    status           = '0;
    status[0]        = (state == REQ);
    status[1]        = err;
    status[2 +: SEL_W] = sel_r;
  end

  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = mask;
      2'd1:    bus.cfg_rdata = pending;
      2'd2:    bus.cfg_rdata = isr;
      default: bus.cfg_rdata = status;
    endcase
  end

  assign bus.irq        = (state == REQ);
  assign bus.irq_vector = vec_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: table-driven single-shot vectors plus
// hand-written sequences for nesting, gating, withdraw, held lines, the
// ack/eoi collision and asynchronous reset.
module tb_interrupt_controller;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  interrupt_controller_if #(.N_IRQ(8), .VEC_WIDTH(10)) bus ();

  interrupt_controller #(
    .N_IRQ(8), .VEC_WIDTH(10), .VEC_BASE(10'h3F0), .VEC_STRIDE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef enum {K_IRQ, K_VEC, K_RD} kind_e;
  typedef struct {
    string      name;
    kind_e      kind;
    logic [1:0] addr;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic [7:0] lines;
    logic [7:0] mask;
    logic       exp_irq;
    logic [9:0] exp_vec;
    logic [7:0] exp_pend;
    logic [7:0] exp_pend_ack;
    logic [7:0] exp_isr_ack;
  } vec_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input kind_e k, input logic [1:0] a,
                          input logic [15:0] e);
    sb_t s;
    s.name = nm; s.kind = k; s.addr = a; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    logic [15:0] act;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      case (s.kind)
        K_IRQ:   act = {15'b0, bus.irq};
        K_VEC:   act = {6'b0, bus.irq_vector};
        default: begin
          bus.cfg_addr = s.addr;
          #1;
          act = {8'b0, bus.cfg_rdata};
        end
      endcase
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    step(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_lines(input logic [7:0] v);
    bus.irq_in = v;
    step(1);
    bus.irq_in = 8'h00;
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1;
    step(1);
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi = 1'b1;
    step(1);
    bus.eoi = 1'b0;
  endtask

  task automatic cleanup();
    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd1, 8'hFF);
  endtask

  vec_t tbl[6];
  int   nreq;
  logic prev_irq;

  initial begin
    tbl[0] = '{8'h08, 8'h00, 1'b1, 10'h3F6, 8'h08, 8'h00, 8'h08};
    tbl[1] = '{8'h01, 8'h00, 1'b1, 10'h3F0, 8'h01, 8'h00, 8'h01};
    tbl[2] = '{8'h80, 8'h00, 1'b1, 10'h3FE, 8'h80, 8'h00, 8'h80};
    tbl[3] = '{8'h22, 8'h00, 1'b1, 10'h3F2, 8'h22, 8'h20, 8'h02};
    tbl[4] = '{8'h90, 8'h10, 1'b1, 10'h3FE, 8'h90, 8'h10, 8'h80};
    tbl[5] = '{8'h40, 8'h40, 1'b0, 10'h000, 8'h40, 8'h40, 8'h00};

    bus.irq_in = 8'h00; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0;
    bus.cfg_wdata = 8'h00; bus.irq_ack = 1'b0; bus.eoi = 1'b0;

    // Reset state
    step(3);
    reset = 1'b1;
    step(2);
    expect_v("rst_irq", K_IRQ, 2'd0, 16'h0);
    expect_v("rst_vec", K_VEC, 2'd0, 16'h3F0);
    expect_v("rst_mask", K_RD, 2'd0, 16'hFF);
    expect_v("rst_pend", K_RD, 2'd1, 16'h00);
    expect_v("rst_isr", K_RD, 2'd2, 16'h00);
    expect_v("rst_status", K_RD, 2'd3, 16'h00);
    drain();

    // Table-driven single requests
    for (int i = 0; i < 6; i++) begin
      cfg_write(2'd0, tbl[i].mask);
      pulse_lines(tbl[i].lines);
      step(1);
      expect_v($sformatf("tbl%0d_irq", i), K_IRQ, 2'd0, {15'b0, tbl[i].exp_irq});
      if (tbl[i].exp_irq)
        expect_v($sformatf("tbl%0d_vec", i), K_VEC, 2'd0, {6'b0, tbl[i].exp_vec});
      expect_v($sformatf("tbl%0d_pend", i), K_RD, 2'd1, {8'b0, tbl[i].exp_pend});
      drain();
      if (tbl[i].exp_irq) begin
        do_ack();
        expect_v($sformatf("tbl%0d_irq_ack", i), K_IRQ, 2'd0, 16'h0);
        expect_v($sformatf("tbl%0d_pend_ack", i), K_RD, 2'd1, {8'b0, tbl[i].exp_pend_ack});
        expect_v($sformatf("tbl%0d_isr_ack", i), K_RD, 2'd2, {8'b0, tbl[i].exp_isr_ack});
        drain();
      end
      cleanup();
      if (tbl[i].exp_irq) begin
        do_eoi();
        expect_v($sformatf("tbl%0d_isr_eoi", i), K_RD, 2'd2, 16'h00);
        drain();
      end
    end

    // Nesting: line 1 preempts in-service line 3, line 5 waits for both eoi
    cfg_write(2'd0, 8'h00);
    pulse_lines(8'h08);
    step(1);
    do_ack();
    expect_v("nest_isr08", K_RD, 2'd2, 16'h08);
    drain();
    pulse_lines(8'h22);
    step(1);
    expect_v("nest_irq1", K_IRQ, 2'd0, 16'h1);
    expect_v("nest_vec1", K_VEC, 2'd0, 16'h3F2);
    drain();
    do_ack();
    expect_v("nest_isr0a", K_RD, 2'd2, 16'h0A);
    expect_v("nest_pend20", K_RD, 2'd1, 16'h20);
    drain();
    step(2);
    expect_v("nest_wait1", K_IRQ, 2'd0, 16'h0);
    drain();
    do_eoi();
    expect_v("nest_eoi1", K_RD, 2'd2, 16'h08);
    drain();
    step(2);
    expect_v("nest_wait2", K_IRQ, 2'd0, 16'h0);
    drain();
    do_eoi();
    expect_v("nest_eoi2", K_RD, 2'd2, 16'h00);
    drain();
    step(1);
    expect_v("nest_irq5", K_IRQ, 2'd0, 16'h1);
    expect_v("nest_vec5", K_VEC, 2'd0, 16'h3FA);
    drain();
    do_ack();
    cleanup();
    do_eoi();

    // ack+eoi in the same cycle, plus a new edge on the acked line
    cfg_write(2'd0, 8'h00);
    pulse_lines(8'h08);
    step(1);
    do_ack();
    pulse_lines(8'h02);
    step(1);
    expect_v("coll_vec", K_VEC, 2'd0, 16'h3F2);
    drain();
    bus.irq_ack = 1'b1; bus.eoi = 1'b1; bus.irq_in = 8'h02;
    step(1);
    bus.irq_ack = 1'b0; bus.eoi = 1'b0; bus.irq_in = 8'h00;
    expect_v("coll_isr", K_RD, 2'd2, 16'h02);
    expect_v("coll_pend", K_RD, 2'd1, 16'h02);
    drain();
    step(2);
    expect_v("coll_noreq", K_IRQ, 2'd0, 16'h0);
    drain();
    cleanup();
    do_eoi();

    // Mask gating
    pulse_lines(8'h01);
    step(1);
    expect_v("gate_pend", K_RD, 2'd1, 16'h01);
    expect_v("gate_irq0", K_IRQ, 2'd0, 16'h0);
    drain();
    cfg_write(2'd0, 8'hFE);
    step(1);
    expect_v("gate_irq1", K_IRQ, 2'd0, 16'h1);
    expect_v("gate_vec", K_VEC, 2'd0, 16'h3F0);
    drain();
    do_ack();
    cleanup();
    do_eoi();

    // Withdraw when the requested line gets masked
    cfg_write(2'd0, 8'h00);
    pulse_lines(8'h04);
    step(1);
    expect_v("wd_vec", K_VEC, 2'd0, 16'h3F4);
    drain();
    cfg_write(2'd0, 8'h04);
    step(1);
    expect_v("wd_irq", K_IRQ, 2'd0, 16'h0);
    expect_v("wd_pend", K_RD, 2'd1, 16'h04);
    expect_v("wd_status", K_RD, 2'd3, 16'h08);
    drain();
    cleanup();

    // Held line gives exactly one request
    cfg_write(2'd0, 8'h00);
    bus.irq_in = 8'h10;
    nreq = 0;
    prev_irq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (bus.irq && !prev_irq) nreq++;
      prev_irq = bus.irq;
      bus.irq_ack = bus.irq;
    end
    bus.irq_ack = 1'b0;
    bus.irq_in = 8'h00;
    chk("held_nreq", nreq, 1);
    expect_v("held_isr", K_RD, 2'd2, 16'h10);
    drain();
    do_eoi();
    expect_v("held_isr0", K_RD, 2'd2, 16'h00);
    drain();
    do_eoi();
    expect_v("err_isr", K_RD, 2'd2, 16'h00);
    expect_v("err_status", K_RD, 2'd3, 16'h12);
    drain();
    cfg_write(2'd3, 8'h80);
    expect_v("err_clear", K_RD, 2'd3, 16'h10);
    drain();

    // irq_ack while idle is ignored
    cfg_write(2'd0, 8'hFF);
    pulse_lines(8'h01);
    step(1);
    do_ack();
    expect_v("idle_ack_isr", K_RD, 2'd2, 16'h00);
    expect_v("idle_ack_pend", K_RD, 2'd1, 16'h01);
    drain();
    cleanup();

    // Asynchronous reset mid-handshake
    cfg_write(2'd0, 8'h00);
    pulse_lines(8'h40);
    step(1);
    expect_v("ar_irq1", K_IRQ, 2'd0, 16'h1);
    expect_v("ar_vec", K_VEC, 2'd0, 16'h3FC);
    drain();
    #2;
    reset = 1'b0;
    #1;
    expect_v("ar_irq0", K_IRQ, 2'd0, 16'h0);
    expect_v("ar_vecbase", K_VEC, 2'd0, 16'h3F0);
    expect_v("ar_pend", K_RD, 2'd1, 16'h00);
    expect_v("ar_mask", K_RD, 2'd0, 16'hFF);
    drain();
    bus.irq_in = 8'hFF;
    step(2);
    reset = 1'b1;
    step(2);
    cfg_write(2'd0, 8'h00);
    step(3);
    expect_v("rel_irq", K_IRQ, 2'd0, 16'h0);
    expect_v("rel_pend", K_RD, 2'd1, 16'h00);
    drain();
    bus.irq_in = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Prioritised, nesting interrupt controller between the interrupt sources (timer, i_o_manager) and the single-cycle cpu.
- Captures rising edges on the 8-bit interruptions bus into a pending register and applies a software-programmable mask.
- Presents one interrupt at a time to the cpu through an irq/irq_ack handshake, with a stable vector.
- Tracks in-service levels until the cpu signals end-of-interrupt (eoi).

Parameters:
- N_IRQ, 8, number of interrupt lines; index 0 is the highest priority.
- VEC_WIDTH, 10, width of the vector (program-address) output.
- VEC_BASE, 10'h3F0, vector of line 0; line i vectors to VEC_BASE + i*VEC_STRIDE.
- VEC_STRIDE, 2, address spacing between vectors; VEC_BASE + (N_IRQ-1)*VEC_STRIDE must fit in VEC_WIDTH bits.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- irq_in, input, N_IRQ: interrupt source lines.
- cfg_we, input, 1: configuration write strobe.
- cfg_addr, input, 2: configuration register select.
- cfg_wdata, input, N_IRQ: configuration write data.
- cfg_rdata, output, N_IRQ: configuration read data, combinational from cfg_addr.
- irq, output, 1: interrupt request to the cpu.
- irq_vector, output, VEC_WIDTH: handler address, valid while irq=1.
- irq_ack, input, 1: one-cycle pulse from the cpu when it takes the interrupt.
- eoi, input, 1: one-cycle pulse from the cpu on handler return.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - irq=0, irq_vector=VEC_BASE, state=IDLE.
  - pending=0, isr=0, mask=all ones (all lines masked), err=0.
  - irq_prev=all ones, so lines already high at reset release do not fire.
- Edge capture: edge = irq_in & ~irq_prev, sampled every clk; irq_prev <= irq_in. pending[i] is set at the edge where edge[i]=1. A line held high produces one event only.
- Candidate: cand = pending & ~mask. sel = lowest set index of cand. cand is eligible if isr==0, or sel < lowest set index of isr (strict preemption only; equal or lower priority waits).
- FSM, two states:
  - IDLE: if an eligible cand exists, register sel, set irq_vector = VEC_BASE + sel*VEC_STRIDE and irq=1, go to REQ.
  - REQ: irq and irq_vector are held constant; a newly arriving higher-priority line does not change them.
    - On irq_ack: pending[sel] cleared, isr[sel] set, irq=0, go to IDLE. IDLE re-arbitrates the next cycle, so there is at least one irq-low cycle between requests.
    - If pending[sel] becomes masked or cleared through cfg while in REQ: withdraw, irq=0, go to IDLE.
- Latency: an edge sampled at clk edge k gives pending at k and irq=1 after edge k+1.
- irq_ack outside REQ is ignored.
- eoi clears the lowest set bit of isr. eoi with isr==0 is ignored and sets the sticky err bit.
- irq_ack and eoi in the same cycle: eoi is applied first to the old isr, then isr[sel] is set.
- A new edge on line i in the same cycle as its ack or pending-clear: pending[i] stays 1, because the event is not lost.
- Configuration registers:
  - addr 0, mask: read/write.
  - addr 1, pending: read; a write of 1 clears that bit.
  - addr 2, isr: read-only.
  - addr 3, status: bit 0 irq, bit 1 err, bits [4:2] sel, bit 7 writes 1 to clear err.
- cfg writes take effect at the clk edge; arbitration uses the updated values from the next cycle.
- Reset asserted mid-handshake drops irq immediately, without waiting for the clock, and discards all pending and in-service state.

Test Plan:
- Reset, then write mask=0x00, pulse irq_in[3] high for 2 cycles -> irq=1 two edges later, irq_vector=0x3F6. Pulse irq_ack -> irq=0, pending=0x00, isr=0x08.
- With isr=0x08, raise irq_in[5] and irq_in[1] together -> irq with vector 0x3F2 (line 1 preempts). After ack, isr=0x0A. Line 5 is not presented until two eoi pulses (isr 0x0A→0x08→0x00), then vector 0x3FA.
- mask=0xFF, raise irq_in[0] -> pending=0x01, irq stays 0. Write mask=0xFE -> irq=1, vector 0x3F0.
- In REQ for line 2, write mask=0x04 -> irq drops the next cycle, state IDLE, pending still 0x04.
- Hold irq_in[4] high for 20 cycles -> exactly one request. eoi with isr=0 -> status err=1, isr unchanged.
- Drive reset low while irq=1 -> irq=0 without waiting for clk. Release reset with irq_in=0xFF held -> no request raised.
